// File: rtl/dmac_apb_pkg.sv
// Shared types and constants for the DMAC APB requester: FSM states,
// default bus widths and the DMAC configuration register map.
package dmac_apb_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;

  // DMAC completer register offsets
  localparam logic [11:0] REG_VER  = 12'h000;
  localparam logic [11:0] REG_SRC  = 12'h100;
  localparam logic [11:0] REG_DST  = 12'h104;
  localparam logic [11:0] REG_LEN  = 12'h108;
  localparam logic [11:0] REG_CMD  = 12'h10C;
  localparam logic [11:0] REG_STAT = 12'h110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/dmac_apb_requester.sv
// APB requester: turns single register-access commands into APB SETUP/ACCESS
// transfers, with wait-state handling, PSLVERR capture and a bounded-wait abort.
module dmac_apb_requester
  import dmac_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_slverr_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic              pslverr_i,
  input  logic [DATA_W-1:0] prdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value at which the next low-PREADY cycle is the TIMEOUT-th one
  localparam logic [CNT_W-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  apb_state_e        state_q;
  logic [CNT_W-1:0]  wait_q;
  logic              cmd_ready_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              slverr_q;
  logic              timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      slverr_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            pwrite_q    <= cmd_write_i;
            paddr_q     <= cmd_addr_i;
            pwdata_q    <= cmd_wdata_i;
            wait_q      <= '0;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // PREADY has priority over an expiring wait counter
          if (pready_i) begin
            rdata_q     <= pwrite_q ? '0 : prdata_i;
            slverr_q    <= pslverr_i;
            timeout_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
            rdata_q     <= '0;
            slverr_q    <= 1'b1;
            timeout_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_slverr_o  = slverr_q;
  assign rsp_timeout_o = timeout_q;

endmodule

// File: tb/tb_dmac_apb_requester.sv
// Bench for dmac_apb_requester: drives commands against a small DMAC completer
// model and checks responses through a scoreboard plus directed APB checks.
module tb_dmac_apb_requester;
  import dmac_apb_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam logic [31:0] VER_VAL = 32'h0001_2024;

  logic          clk;
  logic          rst;
  logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_slverr_o, rsp_timeout_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          psel_o, penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic          pready_i, pslverr_i;
  logic [DW-1:0] prdata_i;

  dmac_apb_requester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_slverr_o(rsp_slverr_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // DMAC completer model with configurable wait states, error and stuck-low PREADY
  int          wait_cfg = 0;
  logic        err_cfg  = 1'b0;
  logic        stuck    = 1'b0;
  int          wcnt     = 0;
  logic [31:0] regs [0:3];

  always_comb begin
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    prdata_i  = '0;
    if (psel_o && penable_o && !stuck && (wcnt >= wait_cfg)) begin
      pready_i  = 1'b1;
      pslverr_i = err_cfg;
      if (!pwrite_o && !err_cfg) begin
        case (paddr_o)
          REG_VER: prdata_i = VER_VAL;
          REG_SRC: prdata_i = regs[0];
          REG_DST: prdata_i = regs[1];
          REG_LEN: prdata_i = regs[2];
          REG_CMD: prdata_i = regs[3];
          default: prdata_i = '0;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    if (psel_o && penable_o && !pready_i) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
    if (psel_o && penable_o && pready_i && pwrite_o && !err_cfg) begin
      case (paddr_o)
        REG_SRC: regs[0] <= pwdata_o;
        REG_DST: regs[1] <= pwdata_o;
        REG_LEN: regs[2] <= pwdata_o;
        REG_CMD: regs[3] <= pwdata_o;
        default: ;
      endcase
    end
  end

  // APB observer: address/control stability and SETUP/ACCESS cycle counts
  logic [AW-1:0] exp_paddr  = '0;
  logic          exp_pwrite = 1'b0;
  logic [DW-1:0] exp_pwdata = '0;
  int            psel_cnt   = 0;
  int            pen_cnt    = 0;

  always @(negedge clk) begin
    if (!rst && psel_o) begin
      check("paddr_stable", 64'(paddr_o), 64'(exp_paddr));
      check("pwrite_stable", 64'(pwrite_o), 64'(exp_pwrite));
      if (pwrite_o) check("pwdata_stable", 64'(pwdata_o), 64'(exp_pwdata));
      psel_cnt <= psel_cnt + 1;
      if (penable_o) pen_cnt <= pen_cnt + 1;
    end
  end

  // Scoreboard: expected response pushed at accept, popped at response handshake
  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    logic        tmo;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];
  logic rsp_seen  = 1'b0;
  int   rsp_first = 0;

  always @(negedge clk) begin
    int   first;
    exp_t e;
    if (rst) begin
      rsp_seen <= 1'b0;
    end else if (rsp_valid_o) begin
      first = rsp_seen ? rsp_first : cyc;
      if (!rsp_seen) begin
        rsp_seen  <= 1'b1;
        rsp_first <= cyc;
      end
      if (rsp_ready_i) begin
        rsp_seen <= 1'b0;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
          check("rsp_slverr", 64'(rsp_slverr_o), 64'(e.slverr));
          check("rsp_timeout", 64'(rsp_timeout_o), 64'(e.tmo));
          check("rsp_latency", 64'(first - e.acc), 64'(e.lat));
        end
      end
    end
  end

  // Issue one command; nacc is the expected number of ACCESS cycles
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [31:0] er, input logic ee, input logic et,
                      input int nacc, output int acc);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_wdata_i = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready_o && n < 100);
    if (!cmd_ready_o) check("cmd_accept_wait", 64'd0, 64'd1);
    exp_paddr = a; exp_pwrite = wr; exp_pwdata = wd;
    acc = cyc;
    e.rdata = er; e.slverr = ee; e.tmo = et; e.lat = 2 + nacc; e.acc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || !cmd_ready_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(sb.size() == 0 && cmd_ready_o), 64'd1);
  endtask

  initial begin
    int a0, a1, ps0, pe0, n;
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) regs[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("reset_psel", 64'(psel_o), 64'd0);
    check("reset_penable", 64'(penable_o), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("reset_paddr", 64'(paddr_o), 64'd0);
    check("reset_rdata", 64'(rsp_rdata_o), 64'd0);

    // Version read, zero wait states
    ps0 = psel_cnt; pe0 = pen_cnt;
    send(1'b0, REG_VER, '0, VER_VAL, 1'b0, 1'b0, 1, a0);
    wait_idle("idle_after_ver");
    check("ver_psel_cycles", 64'(psel_cnt - ps0), 64'd2);
    check("ver_penable_cycles", 64'(pen_cnt - pe0), 64'd1);

    // Back-to-back write then read: 4 cycles per transfer
    send(1'b1, REG_SRC, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1, a0);
    send(1'b0, REG_SRC, '0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, a1);
    check("b2b_accept_spacing", 64'(a1 - a0), 64'd4);
    wait_idle("idle_after_b2b");

    // Three wait states
    send(1'b1, REG_DST, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1, a0);
    wait_idle("idle_after_dst_wr");
    wait_cfg = 3;
    ps0 = psel_cnt; pe0 = pen_cnt;
    send(1'b0, REG_DST, '0, 32'h1234_5678, 1'b0, 1'b0, 4, a0);
    wait_idle("idle_after_wait3");
    check("wait3_access_cycles", 64'(pen_cnt - pe0), 64'd4);
    check("wait3_psel_cycles", 64'(psel_cnt - ps0), 64'd5);
    wait_cfg = 0;

    // Completer error
    err_cfg = 1'b1;
    send(1'b0, REG_LEN, '0, 32'h0, 1'b1, 1'b0, 1, a0);
    wait_idle("idle_after_slverr");
    err_cfg = 1'b0;

    // Timeout abort after 4 low-PREADY ACCESS cycles, then normal recovery
    stuck = 1'b1;
    pe0 = pen_cnt;
    send(1'b0, REG_CMD, '0, 32'h0, 1'b1, 1'b1, 4, a0);
    wait_idle("idle_after_timeout");
    check("timeout_access_cycles", 64'(pen_cnt - pe0), 64'd4);
    stuck = 1'b0;
    send(1'b0, REG_SRC, '0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, a0);
    wait_idle("idle_after_recover");

    // Response back-pressure: held stable, no new command accepted
    rsp_ready_i = 1'b0;
    send(1'b0, REG_VER, '0, VER_VAL, 1'b0, 1'b0, 1, a0);
    n = 0;
    while (!rsp_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      check("hold_rsp_valid", 64'(rsp_valid_o), 64'd1);
      check("hold_rsp_rdata", 64'(rsp_rdata_o), 64'(VER_VAL));
      check("hold_cmd_ready", 64'(cmd_ready_o), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    wait_idle("idle_after_hold");

    // Reset pulsed mid-ACCESS drops the transfer
    stuck = 1'b1;
    send(1'b0, REG_LEN, '0, 32'h0, 1'b0, 1'b0, 1, a0);
    n = 0;
    while (!(psel_o && penable_o) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_access", 64'(psel_o && penable_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_psel", 64'(psel_o), 64'd0);
    check("rst_penable", 64'(penable_o), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    rst = 1'b0;
    sb.delete();
    stuck = 1'b0;

    send(1'b1, REG_LEN, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1, a0);
    send(1'b0, REG_LEN, '0, 32'h0000_0040, 1'b0, 1'b0, 1, a1);
    wait_idle("idle_final");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmac_apb_requester.md
# dmac_apb_requester

APB requester that turns single register-access commands into APB SETUP/ACCESS transfers and returns read data and error status. It is the initiator counterpart of the DMAC configuration completer: testbench/CPU-side logic or a boot sequencer programs DMAC registers (SRC 0x100, DST 0x104, LEN 0x108, CMD 0x10C, STATUS 0x110, VERSION 0x000) through it. It handles completer wait states, PSLVERR, and a bounded-wait timeout.

## Interface
- ADDR_W, 12, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, ACCESS cycles with PREADY low before abort; 0 disables the timeout
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; one clock
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_W  target address
- cmd_wdata_i  in  DATA_W  write data; ignored for reads
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and aborted transfers
- rsp_slverr_o  out  1  PSLVERR seen or timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- psel_o, penable_o, pwrite_o  out  1  APB controls
- paddr_o  out  ADDR_W; pwdata_o  out  DATA_W
- pready_i, pslverr_i  in  1; prdata_i  in  DATA_W

## Operation
- States: IDLE, SETUP, ACCESS, RESP. Reset state IDLE.
- IDLE: cmd_ready_o=1. On cmd_valid_i, latch write/addr/wdata into paddr_o/pwrite_o/pwdata_o and go to SETUP.
- SETUP: psel_o=1, penable_o=0. Go unconditionally to ACCESS.
- ACCESS: psel_o=1, penable_o=1. If pready_i, capture prdata_i (reads only, else 0) and pslverr_i; go to RESP. If pready_i is low, increment the wait counter.
- Timeout: when TIMEOUT≠0 and the counter reaches TIMEOUT (pready_i low in TIMEOUT consecutive ACCESS cycles), abort. Set rdata=0, slverr=1, timeout=1, and go to RESP. pready_i in the same cycle wins over timeout. The counter clears on entry to SETUP.
- RESP: rsp_valid_o=1. Data and flags stay stable until rsp_ready_i, then go to IDLE. psel_o and penable_o are 0.
- paddr_o, pwrite_o and pwdata_o are registered and stay stable from SETUP through ACCESS. They keep their last value afterwards.
- All outputs are registered or decoded directly from state; no combinational path from APB inputs to APB outputs.
- Reset values: all outputs 0 except cmd_ready_o=1 (IDLE); the wait counter is 0.

## Timing
- Minimum transfer (zero wait states): accept at cycle n, SETUP n+1, ACCESS n+2 with pready, rsp_valid_o n+3. With rsp_ready_i=1, IDLE at n+4 and the next accept at n+4. This gives 4 cycles per transfer.
- Each wait state adds one ACCESS cycle.
- A timeout abort puts rsp_valid_o high on the cycle after the TIMEOUT-th low-pready ACCESS cycle.
- rst sampled high at any edge, including mid-ACCESS: psel_o and penable_o are 0 the next cycle. Any pending response is dropped and the state returns to IDLE.
- Commands are never accepted outside IDLE. cmd_valid_i held during busy states is only taken in IDLE.

## Structure
- Package dmac_apb_pkg holds: the state enum (IDLE, SETUP, ACCESS, RESP), the ADDR_W/DATA_W defaults, and the DMAC register offset constants (VER 0x000, SRC 0x100, DST 0x104, LEN 0x108, CMD 0x10C, STAT 0x110).
- Single module with no sub-modules. The wait counter is $clog2(TIMEOUT+1) bits, inline.

## Test plan
- Read 0x000 against the DMAC completer -> rsp_rdata_o=0x0001_2024, slverr=0; psel high 2 cycles, penable high 1 cycle.
- Write 0x100=0xDEAD_BEEF, then read 0x100 -> write response has rdata=0; read returns 0xDEAD_BEEF. The second accept comes exactly 4 cycles after the first.
- Completer holds pready low 3 ACCESS cycles, read 0x104 -> paddr/psel stable for all 4 ACCESS cycles; response on the cycle after pready.
- Completer asserts pslverr with pready -> rsp_slverr_o=1, rsp_timeout_o=0.
- TIMEOUT=4 with pready stuck low -> 4 ACCESS cycles, then rsp_valid with slverr=1, timeout=1, rdata=0. A later command completes normally.
- rsp_ready_i low 5 cycles -> response held stable and cmd_ready_o=0. Separately, rst pulsed mid-ACCESS -> psel_o=0 and cmd_ready_o=1 next cycle.
